// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one single-ported memory bus between the instruction fetch port (I,
//   read-only) and the MEM-stage data port (D, read/write with byte selects).
//   Every access is one req/ack transaction on the bus. While a requester waits,
//   its stall line is held high towards the pipeline controller. Read data is
//   kept in a register until the pipeline advances.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     When defined, a grant that sees no i_bus_ack within TIMEOUT_CYCLES cycles
//     is terminated. o_bus_err pulses for that cycle, the owner gets read data 0,
//     and its ready flag is set as if the slave had acked.
//     When undefined, the FSM waits for ack indefinitely and o_bus_err is tied 0.
//
// Ports
//   i_clk, i_rst_n            clock (rising edge), asynchronous active-low reset
//   i_if_ce / i_if_addr       fetch request and address
//   o_if_rdata / o_stall_if   registered fetch data, fetch stall request
//   i_mem_ce/we/addr/wdata/sel  data-port request
//   o_mem_rdata / o_stall_mem registered data-read result, data stall request
//   i_pipe_stall              pipeline frozen this cycle; when low, the ready flags clear
//   i_flush                   exception flush
//   o_bus_req/we/addr/wdata/sel  bus request and fields; all zero when not granted
//   i_bus_ack / i_bus_rdata   transfer complete and read data, sampled at the clock edge
//   o_bus_err                 timeout pulse

module mem_bus_arbiter #(
  parameter int N_ADDR         = 32,
  parameter int N_DATA         = 32,
  parameter int N_SEL          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_ce,
  input  logic [N_ADDR-1:0] i_if_addr,
  output logic [N_DATA-1:0] o_if_rdata,
  output logic              o_stall_if,
  input  logic              i_mem_ce,
  input  logic              i_mem_we,
  input  logic [N_ADDR-1:0] i_mem_addr,
  input  logic [N_DATA-1:0] i_mem_wdata,
  input  logic [N_SEL-1:0]  i_mem_sel,
  output logic [N_DATA-1:0] o_mem_rdata,
  output logic              o_stall_mem,
  input  logic              i_pipe_stall,
  input  logic              i_flush,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [N_ADDR-1:0] o_bus_addr,
  output logic [N_DATA-1:0] o_bus_wdata,
  output logic [N_SEL-1:0]  o_bus_sel,
  input  logic              i_bus_ack,
  input  logic [N_DATA-1:0] i_bus_rdata,
  output logic              o_bus_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_MEM = 2'd1,
    GRANT_IF  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rdy_if_q, rdy_if_d;
  logic              rdy_mem_q, rdy_mem_d;
  logic              discard_q, discard_d;
  logic [N_DATA-1:0] if_rdata_q, if_rdata_d;
  logic [N_DATA-1:0] mem_rdata_q, mem_rdata_d;

  // Copy of the owner's bus fields taken at grant; drives the bus once a flush
  // has released the owner, whose inputs may then change.
  logic              bus_we_q, bus_we_d;
  logic [N_ADDR-1:0] bus_addr_q, bus_addr_d;
  logic [N_DATA-1:0] bus_wdata_q, bus_wdata_d;
  logic [N_SEL-1:0]  bus_sel_q, bus_sel_d;

  logic              granted;
  logic              timeout;
  logic              done;

  assign granted = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed GRANT cycles; it is 0 in the first one.
  always_comb begin
    cnt_d = '0;
    if (granted && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout   = granted && !i_bus_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_bus_err = timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  assign done = granted && (i_bus_ack || timeout);

  always_comb begin
    state_d     = state_q;
    rdy_if_d    = rdy_if_q;
    rdy_mem_d   = rdy_mem_q;
    discard_d   = discard_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;

    // Pipeline advanced (or was flushed): results have been consumed.
    if (!i_pipe_stall || i_flush) begin
      rdy_if_d  = 1'b0;
      rdy_mem_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // A request presented during a flush belongs to a squashed
        // instruction, so nothing is launched in that cycle.
        if (!i_flush) begin
          if (i_mem_ce && !rdy_mem_q) begin
            state_d     = GRANT_MEM;
            bus_we_d    = i_mem_we;
            bus_addr_d  = i_mem_addr;
            bus_wdata_d = i_mem_wdata;
            bus_sel_d   = i_mem_sel;
          end else if (i_if_ce && !rdy_if_q) begin
            state_d     = GRANT_IF;
            bus_we_d    = 1'b0;
            bus_addr_d  = i_if_addr;
            bus_wdata_d = '0;
            bus_sel_d   = '1;
          end
        end
      end

      GRANT_MEM: begin
        if (done) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          // The set wins over the same-edge clear, so the flag blocks
          // re-issue for one cycle.
          if (!discard_q && !i_flush) begin
            mem_rdata_d = timeout ? '0 : i_bus_rdata;
            rdy_mem_d   = 1'b1;
          end
        end else if (i_flush) begin
          discard_d = 1'b1;
        end
      end

      GRANT_IF: begin
        if (done) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          if (!discard_q && !i_flush) begin
            if_rdata_d = timeout ? '0 : i_bus_rdata;
            rdy_if_d   = 1'b1;
          end
        end else if (i_flush) begin
          discard_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus fields follow the owner's inputs combinationally. After a flush they
  // come from the grant-time copy.
  always_comb begin
    o_bus_req   = 1'b0;
    o_bus_we    = 1'b0;
    o_bus_addr  = '0;
    o_bus_wdata = '0;
    o_bus_sel   = '0;
    if (granted) begin
      o_bus_req = 1'b1;
      if (discard_q) begin
        o_bus_we    = bus_we_q;
        o_bus_addr  = bus_addr_q;
        o_bus_wdata = bus_wdata_q;
        o_bus_sel   = bus_sel_q;
      end else if (state_q == GRANT_MEM) begin
        o_bus_we    = i_mem_we;
        o_bus_addr  = i_mem_addr;
        o_bus_wdata = i_mem_wdata;
        o_bus_sel   = i_mem_sel;
      end else begin
        o_bus_we    = 1'b0;
        o_bus_addr  = i_if_addr;
        o_bus_wdata = '0;
        o_bus_sel   = '1;
      end
    end
  end

  assign o_stall_if  = i_if_ce  && !rdy_if_q  && !i_flush;
  assign o_stall_mem = i_mem_ce && !rdy_mem_q && !i_flush;
  assign o_if_rdata  = if_rdata_q;
  assign o_mem_rdata = mem_rdata_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rdy_if_q    <= 1'b0;
      rdy_mem_q   <= 1'b0;
      discard_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      rdy_if_q    <= rdy_if_d;
      rdy_mem_q   <= rdy_mem_d;
      discard_q   <= discard_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter. Expected bus transactions and read results are
// queued when stimulus is driven. A bus monitor pops an entry at every ack. A
// pipeline monitor pops an entry whenever the pipeline advances past a request.
// Build with +define+ARB_TIMEOUT_EN to include the timeout scenario.

module tb_mem_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_t;

  typedef struct {
    logic        chk;
    logic [31:0] data;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_ce, mem_ce, mem_we, flush, hold_stall;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_rdata, mem_rdata;
  logic        stall_if, stall_mem, pipe_stall;
  logic        bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;

  // slave model
  logic        slave_en;
  int          ws;
  int          wcnt = 0;
  logic [31:0] slave_rdata;

  bus_t exp_bus_q[$];
  rd_t  exp_mem_q[$];
  rd_t  exp_if_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Pipeline controller: frozen while either port stalls or the bench holds it.
  assign pipe_stall = stall_if | stall_mem | hold_stall;
  assign bus_ack    = bus_req && slave_en && (wcnt == ws);
  assign bus_rdata  = slave_rdata;

  always @(posedge clk) begin
    if (!bus_req || bus_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end

  mem_bus_arbiter #(
    .N_ADDR(32), .N_DATA(32), .N_SEL(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_ce(if_ce), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_stall_if(stall_if),
    .i_mem_ce(mem_ce), .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .i_mem_sel(mem_sel), .o_mem_rdata(mem_rdata), .o_stall_mem(stall_mem),
    .i_pipe_stall(pipe_stall), .i_flush(flush),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .o_bus_sel(bus_sel), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata), .o_bus_err(bus_err)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the pipeline to advance, then move to the next cycle.
  task automatic wait_advance(input string tag);
    int n = 0;
    @(negedge clk);
    while (pipe_stall && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk_eq({tag, "_advance"}, pipe_stall, 0);
    tick();
  endtask

  // Bus monitor: every acked transfer must match the next expected transfer.
  always @(negedge clk) begin
    if (rst_n && bus_req && bus_ack) begin
      bus_t e;
      chk_eq("bus_q_nonempty", exp_bus_q.size() != 0, 1);
      if (exp_bus_q.size() != 0) begin
        e = exp_bus_q.pop_front();
        chk_eq("bus_addr", bus_addr, e.addr);
        chk_eq("bus_we", bus_we, e.we);
        chk_eq("bus_sel", bus_sel, e.sel);
        if (e.we) chk_eq("bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  // Pipeline monitor: when the pipeline advances past a request, its data must be valid.
  always @(negedge clk) begin
    if (rst_n && !flush && !pipe_stall) begin
      rd_t r;
      if (mem_ce) begin
        chk_eq("mem_q_nonempty", exp_mem_q.size() != 0, 1);
        if (exp_mem_q.size() != 0) begin
          r = exp_mem_q.pop_front();
          if (r.chk) chk_eq("mem_rdata_consumed", mem_rdata, r.data);
        end
      end
      if (if_ce) begin
        chk_eq("if_q_nonempty", exp_if_q.size() != 0, 1);
        if (exp_if_q.size() != 0) begin
          r = exp_if_q.pop_front();
          if (r.chk) chk_eq("if_rdata_consumed", if_rdata, r.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    if_ce = 0; if_addr = 0; mem_ce = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0;
    mem_sel = 0; flush = 0; hold_stall = 0; slave_en = 1; ws = 0; slave_rdata = 0;
    rst_n = 0;

    // ---- reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_bus_req", bus_req, 0);
    chk_eq("rst_bus_we", bus_we, 0);
    chk_eq("rst_bus_addr", bus_addr, 0);
    chk_eq("rst_bus_wdata", bus_wdata, 0);
    chk_eq("rst_bus_sel", bus_sel, 0);
    chk_eq("rst_if_rdata", if_rdata, 0);
    chk_eq("rst_mem_rdata", mem_rdata, 0);
    chk_eq("rst_bus_err", bus_err, 0);
    chk_eq("rst_stall_if", stall_if, 0);
    chk_eq("rst_stall_mem", stall_mem, 0);
    rst_n = 1;
    tick();

    // ---- zero-wait read
    slave_rdata = 32'hDEADBEEF; ws = 0;
    exp_bus_q.push_back('{32'h100, 1'b0, 32'h0, 4'hF});
    exp_mem_q.push_back('{1'b1, 32'hDEADBEEF});
    mem_ce = 1; mem_we = 0; mem_addr = 32'h100; mem_wdata = 0; mem_sel = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_eq("zw_stall_mem", stall_mem, c < 2);
      chk_eq("zw_bus_req", bus_req, c == 1);
      if (c == 2) chk_eq("zw_mem_rdata", mem_rdata, 32'hDEADBEEF);
      tick();
    end
    mem_ce = 0;
    tick();

    // ---- flush mid-transaction
    slave_rdata = 32'hAAAA5555; ws = 2;
    exp_bus_q.push_back('{32'h300, 1'b0, 32'h0, 4'hF});
    mem_ce = 1; mem_we = 0; mem_addr = 32'h300; mem_sel = 4'hF;
    tick();                    // now in GRANT_MEM
    flush = 1;
    @(negedge clk);
    chk_eq("fl_bus_req", bus_req, 1);
    chk_eq("fl_stall_mem", stall_mem, 0);
    tick();
    flush = 0; mem_ce = 0; mem_addr = 32'hFFFF_FFF0; mem_sel = 4'h0;
    @(negedge clk);
    chk_eq("fl_held_addr", bus_addr, 32'h300);
    chk_eq("fl_held_sel", bus_sel, 4'hF);
    chk_eq("fl_bus_req_held", bus_req, 1);
    tick();                    // ack cycle
    @(negedge clk);
    chk_eq("fl_ack_seen", bus_ack, 1);
    tick();
    slave_rdata = 32'h0BADF00D; ws = 0;
    exp_bus_q.push_back('{32'h304, 1'b0, 32'h0, 4'hF});
    exp_mem_q.push_back('{1'b1, 32'h0BADF00D});
    mem_ce = 1; mem_addr = 32'h304; mem_sel = 4'hF;
    @(negedge clk);
    chk_eq("fl_rdy_not_set", stall_mem, 1);
    chk_eq("fl_rdata_kept", mem_rdata, 32'hDEADBEEF);
    wait_advance("fl_next");
    mem_ce = 0;
    tick();

    // ---- contention: D write and I read in the same cycle, 2 wait states each
    ws = 2; slave_rdata = 32'hCAFEF00D;
    exp_bus_q.push_back('{32'h20, 1'b1, 32'h12345678, 4'b0011});
    exp_bus_q.push_back('{32'h400, 1'b0, 32'h0, 4'hF});
    exp_mem_q.push_back('{1'b0, 32'h0});
    exp_if_q.push_back('{1'b1, 32'hCAFEF00D});
    mem_ce = 1; mem_we = 1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
    if_ce = 1; if_addr = 32'h400;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk_eq("ct_stall_if", stall_if, c < 8);
      chk_eq("ct_stall_mem", stall_mem, c < 4);
      chk_eq("ct_bus_req", bus_req, (c >= 1 && c <= 3) || (c >= 5 && c <= 7));
      tick();
    end
    mem_ce = 0; mem_we = 0; if_ce = 0;
    tick();

    // ---- hold: I ack arrives while the pipeline stays frozen 3 more cycles
    ws = 1; slave_rdata = 32'h13572468; hold_stall = 1;
    exp_bus_q.push_back('{32'h404, 1'b0, 32'h0, 4'hF});
    exp_if_q.push_back('{1'b1, 32'h13572468});
    if_ce = 1; if_addr = 32'h404;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk_eq("hd_stall_if", stall_if, c < 3);
      if (c >= 3) begin
        chk_eq("hd_if_rdata", if_rdata, 32'h13572468);
        chk_eq("hd_no_reissue", bus_req, 0);
      end
      tick();
      if (c == 5) hold_stall = 0;
    end
    if_ce = 0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // ---- timeout: no ack, TIMEOUT_CYCLES = 4
    slave_en = 0;
    exp_if_q.push_back('{1'b1, 32'h0});
    if_ce = 1; if_addr = 32'h408;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_eq("to_bus_err", bus_err, c == 4);
      chk_eq("to_bus_req", bus_req, c >= 1 && c <= 4);
      chk_eq("to_stall_if", stall_if, c < 5);
      if (c == 5) chk_eq("to_if_rdata", if_rdata, 0);
      tick();
    end
    if_ce = 0; slave_en = 1;
    tick();
`endif

    // ---- asynchronous reset during GRANT_IF
    slave_en = 0;
    if_ce = 1; if_addr = 32'h500;
    @(negedge clk);
    chk_eq("rs_idle_req", bus_req, 0);
    tick();
    @(negedge clk);
    chk_eq("rs_grant_req", bus_req, 1);
    chk_eq("rs_grant_addr", bus_addr, 32'h500);
    chk_eq("rs_grant_sel", bus_sel, 4'hF);
    #1 rst_n = 0;
    #1;
    chk_eq("rs_bus_req", bus_req, 0);
    chk_eq("rs_bus_addr", bus_addr, 0);
    chk_eq("rs_bus_sel", bus_sel, 0);
    chk_eq("rs_bus_we", bus_we, 0);
    chk_eq("rs_bus_wdata", bus_wdata, 0);
    chk_eq("rs_if_rdata", if_rdata, 0);
    chk_eq("rs_mem_rdata", mem_rdata, 0);
    chk_eq("rs_bus_err", bus_err, 0);
    chk_eq("rs_stall_if", stall_if, 1);
    if_ce = 0; slave_en = 1;
    @(negedge clk);
    rst_n = 1;
    tick();
    tick();

    chk_eq("end_bus_q", exp_bus_q.size(), 0);
    chk_eq("end_mem_q", exp_mem_q.size(), 0);
    chk_eq("end_if_q", exp_if_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
